// File: rtl/bids22_round_logger.sv
// bids22_round_logger
// Watches the bids22 auction core outputs and detects each completed round
// (a rising edge of roundOver). Each round's record {round_id, winner, price}
// is pushed into a DEPTH-entry FIFO. A host drains the FIFO with rd_en and sees
// the popped record one cycle later, qualified by rd_valid.
//
// Optional feature macro: BIDS22_LOG_STATS_EN
//   defined   -> per-bidder saturating win counters X_wins/Y_wins/Z_wins
//   undefined -> counters are not built and read as constant 0
//
// clr is a synchronous clear of all logger state. It wins over capture and pop.
// The roundOver history keeps tracking through clr, so a level that stays high
// across a clear is not seen again as a new round.
module bids22_round_logger #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     roundOver,
  input  logic                     X_win,
  input  logic                     Y_win,
  input  logic                     Z_win,
  input  logic [31:0]              maxBid,
  input  logic                     rd_en,
  input  logic                     clr,
  output logic                     rd_valid,
  output logic [7:0]               rd_round,
  output logic [1:0]               rd_winner,
  output logic [31:0]              rd_price,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     multi_win,
  output logic [15:0]              X_wins,
  output logic [15:0]              Y_wins,
  output logic [15:0]              Z_wins
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 8 + 2 + 32;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Winner code with fixed priority X > Y > Z; 00 means nobody won.
  function automatic logic [1:0] encode_winner(input logic x, input logic y, input logic z);
    logic [1:0] code;
    if (x) begin
      code = 2'b01;
    end else if (y) begin
      code = 2'b10;
    end else if (z) begin
      code = 2'b11;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  // True when at least two of the three win flags are high.
  function automatic logic two_or_more(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

  logic             ro_prev_r;
  logic [7:0]       round_id_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [RW-1:0]    mem_r [DEPTH];

  logic             detect_s;
  logic             capture_s;
  logic [1:0]       winner_s;
  logic             multi_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [CW-1:0]    count_next_s;

  // Round detect and record fields, derived from the current core outputs.
  always_comb begin
    detect_s  = roundOver & ~ro_prev_r;
    capture_s = 1'b0;
    winner_s  = encode_winner(X_win, Y_win, Z_win);
    multi_s   = two_or_more(X_win, Y_win, Z_win);
    if (clr) begin
      capture_s = 1'b0;
    end else begin
      capture_s = detect_s;
    end
  end

  // Push/pop/drop decisions; a pop on a full FIFO frees the slot for the push.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    if (clr) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
    end else begin
      pop_s = rd_en & (count_r != {CW{1'b0}});
      if (capture_s) begin
        if ((count_r != DEPTH_C) || pop_s) begin
          push_s = 1'b1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        push_s = 1'b0;
        drop_s = 1'b0;
      end
    end
  end

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // roundOver history; keeps tracking through clr so a held level is not re-detected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ro_prev_r <= 1'b0;
    end else begin
      ro_prev_r <= roundOver;
    end
  end

  // Round numbering: every detect consumes a number, dropped or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_id_r <= 8'd0;
    end else if (clr) begin
      round_id_r <= 8'd0;
    end else if (capture_s) begin
      round_id_r <= round_id_r + 8'd1;
    end
  end

  // FIFO pointers, occupancy and the registered empty/full view of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty    <= 1'b1;
      full     <= 1'b0;
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      empty   <= (count_next_s == {CW{1'b0}});
      full    <= (count_next_s == DEPTH_C);
    end
  end

  assign count = count_r;

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {round_id_r, winner_s, maxBid};
    end
  end

  // Pop side: oldest record into the output registers with a one-cycle valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid  <= 1'b0;
      rd_round  <= 8'd0;
      rd_winner <= 2'b00;
      rd_price  <= 32'd0;
    end else if (clr) begin
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= pop_s;
      if (pop_s) begin
        rd_round  <= mem_r[rd_ptr_r][RW-1 -: 8];
        rd_winner <= mem_r[rd_ptr_r][33:32];
        rd_price  <= mem_r[rd_ptr_r][31:0];
      end
    end
  end

  // Sticky error flags: dropped record and ambiguous winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      multi_win <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      multi_win <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow <= 1'b1;
      end
      if (capture_s && multi_s) begin
        multi_win <= 1'b1;
      end
    end
  end

`ifdef BIDS22_LOG_STATS_EN
  // Per-bidder win statistics, counted on every detect including dropped ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      X_wins <= 16'd0;
      Y_wins <= 16'd0;
      Z_wins <= 16'd0;
    end else if (clr) begin
      X_wins <= 16'd0;
      Y_wins <= 16'd0;
      Z_wins <= 16'd0;
    end else if (capture_s) begin
      case (winner_s)
        2'b01:   X_wins <= sat_inc(X_wins);
        2'b10:   Y_wins <= sat_inc(Y_wins);
        2'b11:   Z_wins <= sat_inc(Z_wins);
        default: X_wins <= X_wins;
      endcase
    end
  end
`else
  assign X_wins = 16'd0;
  assign Y_wins = 16'd0;
  assign Z_wins = 16'd0;
`endif

endmodule

// File: tb/tb_bids22_round_logger.sv
// Randomized, self-checking bench for bids22_round_logger. A queue-based model
// of the logger is advanced once per clock and compared against every output
// one time unit after each rising edge; directed scenarios add literal checks.
module tb_bids22_round_logger;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [7:0]  rnd;
    logic [1:0]  win;
    logic [31:0] price;
  } rec_t;

  logic        clk;
  logic        reset_n;
  logic        roundOver;
  logic        X_win;
  logic        Y_win;
  logic        Z_win;
  logic [31:0] maxBid;
  logic        rd_en;
  logic        clr;
  logic        rd_valid;
  logic [7:0]  rd_round;
  logic [1:0]  rd_winner;
  logic [31:0] rd_price;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        multi_win;
  logic [15:0] X_wins;
  logic [15:0] Y_wins;
  logic [15:0] Z_wins;

  bids22_round_logger #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .roundOver(roundOver),
    .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .maxBid(maxBid),
    .rd_en(rd_en), .clr(clr), .rd_valid(rd_valid), .rd_round(rd_round),
    .rd_winner(rd_winner), .rd_price(rd_price), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .multi_win(multi_win),
    .X_wins(X_wins), .Y_wins(Y_wins), .Z_wins(Z_wins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  rec_t q[$];
  bit   m_prev;
  int   m_rid;
  bit   m_ovf;
  bit   m_mw;
  bit   m_rv;
  rec_t m_rd;
  int   m_xw, m_yw, m_zw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev = 1'b0;
    m_rid  = 0;
    m_ovf  = 1'b0;
    m_mw   = 1'b0;
    m_rv   = 1'b0;
    m_rd   = '0;
    m_xw = 0; m_yw = 0; m_zw = 0;
  endtask

  // One clock of the logger's documented behaviour, using the inputs as they stand.
  task automatic model_step();
    bit   det;
    bit   popok;
    int   sz;
    rec_t rec;
    det    = roundOver && !m_prev;
    m_prev = roundOver;
    if (clr) begin
      q.delete();
      m_rid = 0; m_ovf = 1'b0; m_mw = 1'b0; m_rv = 1'b0;
      m_xw = 0; m_yw = 0; m_zw = 0;
    end else begin
      sz    = q.size();
      popok = rd_en && (sz > 0);
      rec   = '0;
      if (det) begin
        rec.rnd   = 8'(m_rid);
        rec.price = maxBid;
        if (X_win)      rec.win = 2'd1;
        else if (Y_win) rec.win = 2'd2;
        else if (Z_win) rec.win = 2'd3;
        else            rec.win = 2'd0;
        if (int'(X_win) + int'(Y_win) + int'(Z_win) > 1) m_mw = 1'b1;
        if (rec.win == 2'd1 && m_xw < 65535) m_xw++;
        if (rec.win == 2'd2 && m_yw < 65535) m_yw++;
        if (rec.win == 2'd3 && m_zw < 65535) m_zw++;
        m_rid = (m_rid + 1) % 256;
      end
      m_rv = popok;
      if (popok) m_rd = q.pop_front();
      if (det) begin
        if (sz < DEPTH || popok) q.push_back(rec);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int xe, ye, ze;
`ifdef BIDS22_LOG_STATS_EN
    xe = m_xw; ye = m_yw; ze = m_zw;
`else
    xe = 0; ye = 0; ze = 0;
`endif
    check("count",     64'(count),     64'(q.size()));
    check("empty",     64'(empty),     64'(q.size() == 0));
    check("full",      64'(full),      64'(q.size() == DEPTH));
    check("overflow",  64'(overflow),  64'(m_ovf));
    check("multi_win", 64'(multi_win), 64'(m_mw));
    check("rd_valid",  64'(rd_valid),  64'(m_rv));
    check("rd_round",  64'(rd_round),  64'(m_rd.rnd));
    check("rd_winner", 64'(rd_winner), 64'(m_rd.win));
    check("rd_price",  64'(rd_price),  64'(m_rd.price));
    check("X_wins",    64'(X_wins),    64'(xe));
    check("Y_wins",    64'(Y_wins),    64'(ye));
    check("Z_wins",    64'(Z_wins),    64'(ze));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_round(input logic x, input logic y, input logic z, input logic [31:0] p);
    roundOver = 1'b1; X_win = x; Y_win = y; Z_win = z; maxBid = p;
    step();
    roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    maxBid = 32'd0; rd_en = 1'b0; clr = 1'b0;
    model_reset();
    #23;
    compare_all();
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_count", 64'(count), 64'd0);
    #7;
    reset_n = 1'b1;

    // basic capture
    do_round(1'b0, 1'b1, 1'b0, 32'h0000_1234);
    check("basic_count", 64'(count), 64'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("basic_valid",  64'(rd_valid),  64'd1);
    check("basic_round",  64'(rd_round),  64'd0);
    check("basic_winner", 64'(rd_winner), 64'd2);
    check("basic_price",  64'(rd_price),  64'h1234);
    check("basic_empty",  64'(empty),     64'd1);
    step();
    check("basic_valid_fall", 64'(rd_valid), 64'd0);

    // overflow: 9 rounds into an 8-deep FIFO
    do_clr();
    for (int i = 0; i < 9; i++) do_round(1'b1, 1'b0, 1'b0, 32'(i + 100));
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd8);
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("ovf_drain_round", 64'(rd_round), 64'(i));
    end
    rd_en = 1'b0;
    step();
    check("ovf_drained_empty", 64'(empty), 64'd1);
    do_round(1'b0, 1'b0, 1'b1, 32'hCAFE_0009);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("ovf_tenth_round", 64'(rd_round), 64'd9);

    // full with simultaneous pop
    do_clr();
    for (int i = 0; i < 8; i++) do_round(1'b0, 1'b1, 1'b0, 32'(i));
    check("fp_full", 64'(full), 64'd1);
    roundOver = 1'b1; X_win = 1'b1; maxBid = 32'h0BAD_F00D; rd_en = 1'b1;
    step();
    check("fp_count", 64'(count), 64'd8);
    check("fp_ovf", 64'(overflow), 64'd0);
    check("fp_valid", 64'(rd_valid), 64'd1);
    check("fp_round", 64'(rd_round), 64'd0);
    roundOver = 1'b0; X_win = 1'b0;
    for (int i = 0; i < 8; i++) step();
    rd_en = 1'b0;
    step();

    // multi-win and no-win
    do_clr();
    do_round(1'b1, 1'b0, 1'b1, 32'hAAAA_5555);
    do_round(1'b0, 1'b0, 1'b0, 32'h0000_BEEF);
    check("mw_flag", 64'(multi_win), 64'd1);
    rd_en = 1'b1;
    step();
    check("mw_winner", 64'(rd_winner), 64'd1);
    step();
    check("nowin_winner", 64'(rd_winner), 64'd0);
    check("nowin_price", 64'(rd_price), 64'h0000_BEEF);
    rd_en = 1'b0;

    // held level gives one record
    do_clr();
    roundOver = 1'b1;
    for (int i = 0; i < 10; i++) step();
    roundOver = 1'b0;
    step();
    check("held_count", 64'(count), 64'd1);

    // clr together with rd_en on a non-empty FIFO
    rd_en = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0; rd_en = 1'b0;
    check("clr_valid", 64'(rd_valid), 64'd0);
    check("clr_count", 64'(count), 64'd0);
    do_round(1'b0, 1'b1, 1'b0, 32'd7);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("clr_round_restart", 64'(rd_round), 64'd0);

    // round_id wrap with continuous reads
    do_clr();
    rd_en = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      roundOver = 1'b1;
      X_win = 1'($urandom_range(0, 1));
      Y_win = 1'($urandom_range(0, 1));
      Z_win = 1'($urandom_range(0, 1));
      maxBid = $urandom;
      step();
      roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
      step();
      if (k == 255) check("wrap_255", 64'(rd_round), 64'd255);
      if (k == 256) check("wrap_0", 64'(rd_round), 64'd0);
    end
    rd_en = 1'b0;

    // statistics
    do_clr();
    for (int i = 0; i < 3; i++) do_round(1'b1, 1'b0, 1'b0, 32'd1);
    do_round(1'b0, 1'b0, 1'b1, 32'd2);
`ifdef BIDS22_LOG_STATS_EN
    check("stats_x", 64'(X_wins), 64'd3);
    check("stats_y", 64'(Y_wins), 64'd0);
    check("stats_z", 64'(Z_wins), 64'd1);
`else
    check("stats_x_off", 64'(X_wins), 64'd0);
    check("stats_y_off", 64'(Y_wins), 64'd0);
    check("stats_z_off", 64'(Z_wins), 64'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      roundOver = ($urandom_range(0, 2) != 0) ? ~roundOver : roundOver;
      X_win  = 1'($urandom_range(0, 1));
      Y_win  = 1'($urandom_range(0, 1));
      Z_win  = 1'($urandom_range(0, 1));
      maxBid = $urandom;
      rd_en  = ($urandom_range(0, 3) == 0);
      clr    = ($urandom_range(0, 63) == 0);
      step();
    end
    clr = 1'b0; rd_en = 1'b0; roundOver = 1'b0;
    step();

    // asynchronous reset in the middle of a drain
    do_clr();
    for (int i = 0; i < 3; i++) do_round(1'b0, 1'b1, 1'b0, 32'(i + 5));
    rd_en = 1'b1;
    step();
    reset_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(rd_valid), 64'd0);
    rd_en = 1'b0;
    #2;
    reset_n = 1'b1;
    do_round(1'b0, 1'b0, 1'b1, 32'h55);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("arst_round_restart", 64'(rd_round), 64'd0);
    check("arst_winner", 64'(rd_winner), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
